// File: rtl/psum_accum_relu_if.sv
// psum_accum_relu_if: FIFO-bank pop port and ReLU output handshake of the psum accumulator
interface psum_accum_relu_if #(parameter int col = 8, parameter int psum_bw = 16);
  logic [col*psum_bw-1:0] in;
  logic [col*psum_bw-1:0] out;
  logic fifo_valid;
  logic fifo_rd;
  logic out_valid;
  logic out_ready;
  modport master(output in, fifo_valid, out_ready, input fifo_rd, out, out_valid);
  modport slave(input in, fifo_valid, out_ready, output fifo_rd, out, out_valid);
endinterface

// File: rtl/psum_accum_relu.sv
// psum_accum_relu: sums nij-deep psum words over kij passes, then drains them through per-lane ReLU
module psum_accum_relu #(
  parameter int col = 8,
  parameter int psum_bw = 16,
  parameter int nij = 16,
  parameter int kij = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  psum_accum_relu_if.slave bus,
  output logic busy,
  output logic done
);
  localparam int aw = $clog2(nij);
  localparam int kw = kij > 1 ? $clog2(kij) : 1;
  localparam int w = col * psum_bw;
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [aw-1:0] nij_cnt, rd_addr;
  logic [kw-1:0] kij_cnt;
  logic [w-1:0] acc [nij];
  logic [w-1:0] acc_nxt, relu_w;
  logic pop, last_nij, last_kij;
  assign pop = state == ACCUM && bus.fifo_valid;
  assign last_nij = nij_cnt == aw'(nij - 1);
  assign last_kij = kij_cnt == kw'(kij - 1);
  // nij_cnt doubles as the drain address; once out is valid the next word comes from the following entry
  assign rd_addr = bus.out_valid ? nij_cnt + 1'b1 : nij_cnt;
  for (genvar l = 0; l < col; l++) begin : g_lane
    logic [psum_bw-1:0] a, b, r;
    logic [psum_bw:0] s;
    assign a = acc[nij_cnt][l*psum_bw +: psum_bw];
    assign b = bus.in[l*psum_bw +: psum_bw];
    assign s = {a[psum_bw-1], a} + {b[psum_bw-1], b};
    assign acc_nxt[l*psum_bw +: psum_bw] = kij_cnt == '0 ? b :
      s[psum_bw] ^ s[psum_bw-1] ? {s[psum_bw], {(psum_bw-1){~s[psum_bw]}}} : s[psum_bw-1:0];
    assign r = acc[rd_addr][l*psum_bw +: psum_bw];
    assign relu_w[l*psum_bw +: psum_bw] = r[psum_bw-1] ? '0 : r;
  end
  always_ff @(posedge clk) begin
    if (pop) acc[nij_cnt] <= acc_nxt;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      nij_cnt <= '0;
      kij_cnt <= '0;
      bus.out <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      state <= nxt;
      if (pop) begin
        nij_cnt <= last_nij ? '0 : nij_cnt + 1'b1;
        if (last_nij) kij_cnt <= last_kij ? '0 : kij_cnt + 1'b1;
      end
      if (state == DRAIN && (!bus.out_valid || bus.out_ready)) begin
        if (bus.out_valid && last_nij) begin
          bus.out_valid <= 1'b0;
          nij_cnt <= '0;
        end else begin
          bus.out <= relu_w;
          bus.out_valid <= 1'b1;
          nij_cnt <= rd_addr;
        end
      end
    end
  end
  always_comb begin
    nxt = state == IDLE  ? (start ? ACCUM : IDLE) :
          state == ACCUM ? (pop && last_nij && last_kij ? DRAIN : ACCUM) :
          state == DRAIN ? (bus.out_valid && bus.out_ready && last_nij ? DONE : DRAIN) : IDLE;
  end
  always_comb begin
    bus.fifo_rd = pop;
    busy = state == ACCUM || state == DRAIN;
    done = state == DONE;
  end
endmodule

// File: tb/tb_psum_accum_relu.sv
// tb_psum_accum_relu: directed vectors on three instances (nij=4, kij=1/2/3) fed by a modelled FIFO bank
module tb_psum_accum_relu;
  typedef struct {
    int k;
    int lane;
    int pv[3];
    int step;
    int oth;
    int exp[4];
    int eoth;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [2:0] start = '0, gate = '1, rdy = '1, flush = '0;
  logic [127:0] stim [3][256];
  int head [3];
  int tail [3];
  logic rd [3], fv [3], oval [3], busy [3], done [3];
  logic [127:0] ov [3];
  vec_t tv [8];
  int nvec = 0, nfail = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 3; g++) begin : g_u
    psum_accum_relu_if #(.col(8), .psum_bw(16)) bus();
    assign bus.in = stim[g][head[g]];
    assign bus.fifo_valid = gate[g] && head[g] != tail[g];
    assign bus.out_ready = rdy[g];
    assign rd[g] = bus.fifo_rd;
    assign fv[g] = bus.fifo_valid;
    assign ov[g] = bus.out;
    assign oval[g] = bus.out_valid;
    psum_accum_relu #(.col(8), .psum_bw(16), .nij(4), .kij(g + 1)) u_dut (
      .clk(clk), .reset(reset), .start(start[g]), .bus(bus), .busy(busy[g]), .done(done[g]));
  end
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (flush[k]) head[k] <= tail[k];
      else if (rd[k]) head[k] <= head[k] + 1;
    end
  end
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic push(input int k, input logic [127:0] word);
    stim[k][tail[k]] = word;
    tail[k]++;
  endtask
  task automatic run_job(input int vi, input bit stress, input bit dstart);
    vec_t v;
    int k, n, np, first;
    bit last, fin, stall;
    logic [127:0] prev, word;
    logic [127:0] got [4];
    v = tv[vi];
    k = v.k;
    n = 0; np = 0; first = -1; last = 0; fin = 0; stall = 0; prev = '0;
    for (int j = 0; j < 4; j++) got[j] = '0;
    for (int p = 0; p <= k; p++)
      for (int j = 0; j < 4; j++) begin
        for (int l = 0; l < 8; l++) word[l*16 +: 16] = 16'(l == v.lane ? v.pv[p] + v.step * j : v.oth);
        push(k, word);
      end
    @(posedge clk); #1 start[k] = 1'b1;
    @(posedge clk); #1 start[k] = 1'b0;
    for (int c = 0; c < 600 && !fin; c++) begin
      if (stress) begin
        gate[k] = c % 2 == 0;
        rdy[k] = 1'($urandom_range(0, 1));
      end
      if (dstart) start[k] = oval[k];
      @(negedge clk);
      if (!fv[k] || oval[k]) chk("no_pop", 128'(rd[k]), 128'd0);
      if (rd[k]) np++;
      if (stall) begin
        chk("stall_hold", ov[k], prev);
        chk("stall_valid", 128'(oval[k]), 128'd1);
      end
      stall = oval[k] && !rdy[k];
      prev = ov[k];
      if (first < 0 && oval[k]) first = c;
      if (last) begin
        chk("done_pulse", {125'd0, done[k], busy[k], oval[k]}, 128'b100);
        fin = 1;
      end else if (oval[k] && rdy[k]) begin
        got[n] = ov[k];
        n++;
        last = n == 4;
      end
      if (!fin) begin
        @(posedge clk); #1;
      end
    end
    start[k] = 1'b0; gate[k] = 1'b1; rdy[k] = 1'b1;
    chk("job_finished", 128'(fin), 128'd1);
    for (int j = 0; j < 4; j++) begin
      for (int l = 0; l < 8; l++) word[l*16 +: 16] = 16'(l == v.lane ? v.exp[j] : v.eoth);
      chk($sformatf("vec%0d_word%0d", vi, j), got[j], word);
    end
    chk("pop_count", 128'(np), 128'(4 * (k + 1)));
    if (!stress) chk("latency", 128'(first), 128'(4 * (k + 1) + 1));
    @(negedge clk);
    chk("idle_after", {126'd0, done[k], busy[k]}, 128'd0);
  endtask
  initial begin
    int np;
    tv[0] = '{0, 0, '{1, 0, 0}, 1, 0, '{1, 2, 3, 4}, 0};
    tv[1] = '{2, 0, '{5, 5, 5}, 0, 5, '{15, 15, 15, 15}, 15};
    tv[2] = '{2, 3, '{20000, 20000, 20000}, 0, 0, '{32767, 32767, 32767, 32767}, 0};
    tv[3] = '{2, 3, '{-20000, -20000, -20000}, 0, 0, '{0, 0, 0, 0}, 0};
    tv[4] = '{1, 1, '{-7, 3, 0}, 0, 1, '{0, 0, 0, 0}, 2};
    tv[5] = '{1, 1, '{7, -3, 0}, 0, -1, '{4, 4, 4, 4}, 0};
    tv[6] = '{2, 7, '{10, -20, 100}, 1000, -3, '{90, 3090, 6090, 9090}, 0};
    tv[7] = '{2, 2, '{16384, 16384, -1}, 0, 0, '{32766, 32766, 32766, 32766}, 0};
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("reset_out", ov[k], 128'd0);
      chk("reset_ctl", {124'd0, rd[k], oval[k], busy[k], done[k]}, 128'd0);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 8; i++) run_job(i, 1'b0, 1'b0);
    run_job(1, 1'b1, 1'b0);
    np = 0;
    for (int j = 0; j < 12; j++) push(2, {8{16'd100}});
    @(posedge clk); #1 start[2] = 1'b1;
    @(posedge clk); #1 start[2] = 1'b0;
    for (int c = 0; c < 50 && np < 5; c++) begin
      @(negedge clk);
      if (rd[2]) np++;
      if (np < 5) begin
        @(posedge clk); #1;
      end
    end
    chk("abort_pops", 128'(np), 128'd5);
    @(posedge clk); #1 reset = 1'b0; flush[2] = 1'b1;
    #1;
    chk("abort_out", ov[2], 128'd0);
    chk("abort_ctl", {124'd0, rd[2], oval[2], busy[2], done[2]}, 128'd0);
    @(posedge clk); #1 flush[2] = 1'b0; reset = 1'b1;
    run_job(6, 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
